// File: rtl/c_drain_serialize_m_axi_fifo.sv
// ---------------------------------------------------------------------------
// c_drain_serialize_m_axi_fifo
//
// First-word-fall-through FIFO between the serialize_C drain stream and the
// C m_axi write-data channel. Storage is a simple-dual-port RAM with a
// registered read address and registered read data (2-cycle read latency).
// A prefetch engine moves words from the RAM into a 2-entry output skid
// queue, and the consumer sees the skid head as the FIFO head.
//
// Parameters:
//   MEM_STYLE   RAM inference style attribute for the storage array
//   DATA_WIDTH  word width
//   ADDR_WIDTH  RAM address width
//   DEPTH       total capacity in words (RAM holds DEPTH-1)
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   if_write_ce/if_write     push enable / push request
//   if_din                   push data
//   if_full_n                1 = space available (registered)
//   if_read_ce/if_read       pop enable / pop request
//   if_dout                  head word, valid while if_empty_n = 1
//   if_empty_n               1 = head word valid (registered)
//   if_usedw                 registered total word count; present only when
//                            C_DRAIN_FIFO_USEDW_EN is defined
// ---------------------------------------------------------------------------
module c_drain_serialize_m_axi_fifo #(
  parameter     MEM_STYLE  = "auto",
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 63
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
`ifdef C_DRAIN_FIFO_USEDW_EN
  output logic [ADDR_WIDTH:0]   if_usedw,
`endif
  output logic                  if_empty_n
);

  localparam int                  CW        = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 2);
  localparam logic [CW-1:0]       DEPTH_C   = CW'(DEPTH);

  // Storage array; contents are never reset.
  (* ram_style = MEM_STYLE *) logic [DATA_WIDTH-1:0] mem [0:DEPTH-2];

  // Pointers and counters
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [CW-1:0]         ram_used_q, ram_used_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_n_q, full_n_d;

  // RAM read pipeline: stage 1 = address registered, stage 2 = data registered
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_vld1_q, rd_vld2_q;

  // Output skid queue
  logic [DATA_WIDTH-1:0] skid0_q, skid0_d;
  logic [DATA_WIDTH-1:0] skid1_q, skid1_d;
  logic [1:0]            skid_used_q, skid_used_d;
  logic                  empty_n_q, empty_n_d;

  // Handshake and prefetch control
  logic       push, pop, issue, append;
  logic [2:0] busy;
  logic [1:0] used_after_pop;

  always_comb begin
    push   = if_write_ce & if_write & full_n_q;
    pop    = if_read_ce & if_read & empty_n_q;
    append = rd_vld2_q;

    // Words already committed to the skid path, minus the slot freed by a
    // pop this cycle. pop implies skid_used_q >= 1, so no underflow.
    busy  = 3'(rd_vld1_q) + 3'(rd_vld2_q) + 3'(skid_used_q) - 3'(pop);
    issue = (ram_used_q != '0) && (busy < 3'd2);

    wptr_d = wptr_q;
    if (push) begin
      wptr_d = (wptr_q == LAST_ADDR) ? '0 : wptr_q + 1'b1;
    end

    rptr_d = rptr_q;
    if (issue) begin
      rptr_d = (rptr_q == LAST_ADDR) ? '0 : rptr_q + 1'b1;
    end

    ram_used_d = ram_used_q + CW'(push) - CW'(issue);
    count_d    = count_q + CW'(push) - CW'(pop);
    full_n_d   = (count_d < DEPTH_C);

    // Pop shifts the second entry forward; a returning read lands in the
    // first free slot after that shift.
    used_after_pop = skid_used_q - 2'(pop);
    skid0_d        = pop ? skid1_q : skid0_q;
    skid1_d        = skid1_q;
    if (append) begin
      if (used_after_pop == 2'd0) begin
        skid0_d = rd_data_q;
      end else begin
        skid1_d = rd_data_q;
      end
    end
    skid_used_d = used_after_pop + 2'(append);
    empty_n_d   = (skid_used_d != 2'd0);
  end

  // RAM write port
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= if_din;
    end
  end

  // RAM read port: registered address, then registered data
  always_ff @(posedge clk) begin
    if (issue) begin
      rd_addr_q <= rptr_q;
    end
    if (rd_vld1_q) begin
      rd_data_q <= mem[rd_addr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      ram_used_q  <= '0;
      count_q     <= '0;
      full_n_q    <= 1'b1;
      rd_vld1_q   <= 1'b0;
      rd_vld2_q   <= 1'b0;
      skid0_q     <= '0;
      skid1_q     <= '0;
      skid_used_q <= '0;
      empty_n_q   <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      ram_used_q  <= ram_used_d;
      count_q     <= count_d;
      full_n_q    <= full_n_d;
      rd_vld1_q   <= issue;
      rd_vld2_q   <= rd_vld1_q;
      skid0_q     <= skid0_d;
      skid1_q     <= skid1_d;
      skid_used_q <= skid_used_d;
      empty_n_q   <= empty_n_d;
    end
  end

  assign if_full_n  = full_n_q;
  assign if_empty_n = empty_n_q;
  assign if_dout    = skid0_q;
`ifdef C_DRAIN_FIFO_USEDW_EN
  assign if_usedw   = count_q;
`endif

endmodule
